// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The overflow bound is derived here from the digit count.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Largest value representable in the given number of decimal digits.
    function automatic int unsigned max_val(input int digits);
        int unsigned v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a producer of binary values and the converter.
// The slave side is the converter; the master side requests conversions.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  overflow,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output overflow,
        output bcd_out
    );
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] in_i,
    output logic [3:0] out_o
);
    assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary to packed-BCD converter, one input bit per clock.
// Result and overflow flag are registered so the display only changes on completion.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int          BCD_W    = 4 * DIGITS;
    localparam int          CNT_W    = $clog2(BIN_W + 1);
    localparam logic [31:0] MAX_VAL  = max_val(DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_e               state_q, state_d;
    logic [BIN_W-1:0]     shift_q, shift_d;
    logic [BCD_W-1:0]     scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;

    logic [BCD_W-1:0]       adjusted;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic                   too_big;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in_i  (scratch_q[4*g +: 4]),
            .out_o (adjusted[4*g +: 4])
        );
    end

    assign shifted = {adjusted, shift_q} << 1;
    assign too_big = 32'(bus.bin_in) > MAX_VAL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    // Result registers load only on the edge that enters DONE.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d   = bus.bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    if (too_big) begin
                        state_d = DONE;
                        bcd_d   = {DIGITS{DIGIT_BLANK}};
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shift_d   = shifted[BIN_W-1:0];
                scratch_d = shifted[BCD_W+BIN_W-1:BIN_W];
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    bcd_d   = shifted[BCD_W+BIN_W-1:BIN_W];
                    ovf_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.overflow = ovf_q;
    assign bus.bcd_out  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: vector table, random values against a decimal
// reference model, and hand-written sequences for start/reset corner cases.
module tb_bin2bcd_seq;

    logic clk;
    logic rst_n;
    int   nCompared;
    int   nMismatched;

    bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus_if ();

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] val;
        logic [15:0] expBcd;
        logic        expOvf;
        int          expLat;
    } vec_t;

    vec_t vecs[12];

    // Decimal digits from plain arithmetic; anything above 9999 shows dashes.
    function automatic logic [15:0] refBcd(input int v);
        if (v > 9999) return 16'hFFFF;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts one conversion from an IDLE negedge and returns on the next IDLE negedge.
    task automatic applyStimulus(input logic [13:0] val, input logic [15:0] expBcd,
                                 input logic expOvf, input int expLat, input string tag);
        int   lat;
        logic busyOk;
        lat    = -1;
        busyOk = 1'b1;
        bus_if.start  = 1'b1;
        bus_if.bin_in = val;
        @(posedge clk);
        #1;
        bus_if.start  = 1'b0;
        bus_if.bin_in = 14'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus_if.busy !== 1'b1) busyOk = 1'b0;
            if (bus_if.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " busy"}, 32'(busyOk), 32'd1);
        checkOutput({tag, " bcd_out"}, 32'(bus_if.bcd_out), 32'(expBcd));
        checkOutput({tag, " overflow"}, 32'(bus_if.overflow), 32'(expOvf));
        @(negedge clk);
        checkOutput({tag, " idle busy"}, 32'(bus_if.busy), 32'd0);
        checkOutput({tag, " held bcd"}, 32'(bus_if.bcd_out), 32'(expBcd));
    endtask

    initial begin
        int          doneCycles[$];
        int          idleCycles[$];
        int          doneCount;
        logic [13:0] rv;

        nCompared   = 0;
        nMismatched = 0;

        vecs[0]  = '{14'd0,     16'h0000, 1'b0, 15};
        vecs[1]  = '{14'd1234,  16'h1234, 1'b0, 15};
        vecs[2]  = '{14'd9999,  16'h9999, 1'b0, 15};
        vecs[3]  = '{14'd5,     16'h0005, 1'b0, 15};
        vecs[4]  = '{14'd10000, 16'hFFFF, 1'b1, 1};
        vecs[5]  = '{14'd42,    16'h0042, 1'b0, 15};
        vecs[6]  = '{14'd16383, 16'hFFFF, 1'b1, 1};
        vecs[7]  = '{14'd42,    16'h0042, 1'b0, 15};
        vecs[8]  = '{14'd9,     16'h0009, 1'b0, 15};
        vecs[9]  = '{14'd10,    16'h0010, 1'b0, 15};
        vecs[10] = '{14'd1000,  16'h1000, 1'b0, 15};
        vecs[11] = '{14'd5959,  16'h5959, 1'b0, 15};

        rst_n         = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.bin_in = '0;
        #2;
        checkOutput("reset busy", 32'(bus_if.busy), 32'd0);
        checkOutput("reset done", 32'(bus_if.done), 32'd0);
        checkOutput("reset overflow", 32'(bus_if.overflow), 32'd0);
        checkOutput("reset bcd_out", 32'(bus_if.bcd_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].val, vecs[i].expBcd, vecs[i].expOvf, vecs[i].expLat,
                          $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            rv = 14'($urandom_range(0, 16383));
            applyStimulus(rv, refBcd(int'(rv)), rv > 14'd9999, (rv > 14'd9999) ? 1 : 15,
                          $sformatf("rand%0d(%0d)", i, rv));
        end

        // Starts during SHIFT and DONE must be dropped, not queued.
        doneCount     = 0;
        bus_if.start  = 1'b1;
        bus_if.bin_in = 14'd1234;
        @(posedge clk);
        #1;
        bus_if.start  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) begin
                doneCount++;
                checkOutput("ignore done cycle", 32'(k), 32'd15);
            end
            if (k == 17) checkOutput("ignore busy after", 32'(bus_if.busy), 32'd0);
            bus_if.start  = (k == 3 || k == 15);
            bus_if.bin_in = 14'd7777;
        end
        bus_if.start = 1'b0;
        checkOutput("ignore done count", 32'(doneCount), 32'd1);
        checkOutput("ignore bcd_out", 32'(bus_if.bcd_out), 32'h1234);

        // Reset mid-conversion aborts and clears a previously flagged overflow.
        applyStimulus(14'd12000, 16'hFFFF, 1'b1, 1, "pre-reset ovf");
        bus_if.start  = 1'b1;
        bus_if.bin_in = 14'd8888;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        for (int k = 1; k <= 6; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(bus_if.busy), 32'd0);
        checkOutput("abort done", 32'(bus_if.done), 32'd0);
        checkOutput("abort bcd_out", 32'(bus_if.bcd_out), 32'h0);
        checkOutput("abort overflow", 32'(bus_if.overflow), 32'd0);
        doneCount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) doneCount++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) doneCount++;
        end
        checkOutput("abort no done", 32'(doneCount), 32'd0);
        applyStimulus(14'd321, 16'h0321, 1'b0, 15, "post-reset");

        // Held start gives back-to-back conversions with a single idle cycle between.
        bus_if.start  = 1'b1;
        bus_if.bin_in = 14'd4321;
        @(posedge clk);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) begin
                doneCycles.push_back(k);
                checkOutput($sformatf("held bcd@%0d", k), 32'(bus_if.bcd_out), 32'h4321);
            end
            if (bus_if.busy !== 1'b1) idleCycles.push_back(k);
        end
        bus_if.start = 1'b0;
        checkOutput("held done count", 32'(doneCycles.size()), 32'd3);
        checkOutput("held idle count", 32'(idleCycles.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < doneCycles.size())
                checkOutput($sformatf("held done%0d", i), 32'(doneCycles[i]), 32'(15 + 16 * i));
            if (i < idleCycles.size())
                checkOutput($sformatf("held idle%0d", i), 32'(idleCycles[i]), 32'(16 + 16 * i));
        end
        for (int k = 0; k < 40 && bus_if.busy === 1'b1; k++) @(negedge clk);
        checkOutput("held final idle", 32'(bus_if.busy), 32'd0);
        checkOutput("held final bcd", 32'(bus_if.bcd_out), 32'h4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
